// File: rtl/program_load_controller.sv
// Load/run sequencer for the single-cycle core: streams a program into imem, then runs the core to halt or timeout.
// Optional feature macro: PLC_CHECKSUM_EN (running sum of loaded words on the checksum output).
module program_load_controller #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int RES_W      = 64,
  parameter int MAX_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_rst,
  input  logic              core_halt,
  input  logic [RES_W-1:0]  core_res,
  output logic [RES_W-1:0]  result,
  output logic              done,
  output logic              timeout,
  output logic              overflow,
  output logic [31:0]       cycle_cnt,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [31:0] LP_MAX = 32'(MAX_CYCLES);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_ptr;
  logic                r_imem_we;
  logic [ADDR_W-1:0]   r_imem_addr;
  logic [DATA_W-1:0]   r_imem_wdata;
  logic                r_core_rst;
  logic [RES_W-1:0]    r_result;
  logic                r_done;
  logic                r_timeout;
  logic                r_overflow;
  logic [31:0]         r_cycle_cnt;
  logic                w_accept;
  logic                w_ptr_max;
  logic [31:0]         w_cnt_next;
  logic                w_limit_hit;
`ifdef PLC_CHECKSUM_EN
  logic [DATA_W-1:0]   r_checksum;
`endif

  assign ld_ready    = (r_state == S_LOAD);
  assign w_accept    = ld_valid & ld_ready;
  assign w_ptr_max   = (r_ptr == {ADDR_W{1'b1}});
  assign w_cnt_next  = r_cycle_cnt + 32'd1;
  assign w_limit_hit = (w_cnt_next == LP_MAX);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) w_next = S_LOAD;
          else       w_next = r_state;
        end
        S_LOAD: begin
          if (w_accept && ld_last)        w_next = S_FLUSH;
          else if (w_accept && w_ptr_max) w_next = S_DONE;
          else                            w_next = S_LOAD;
        end
        S_FLUSH: w_next = S_RUN;
        S_RUN: begin
          if (core_halt || w_limit_hit) w_next = S_DONE;
          else                          w_next = S_RUN;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Datapath: imem write port, run counter, result capture and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr        <= {ADDR_W{1'b0}};
      r_imem_we    <= 1'b0;
      r_imem_addr  <= {ADDR_W{1'b0}};
      r_imem_wdata <= {DATA_W{1'b0}};
      r_core_rst   <= 1'b0;
      r_result     <= {RES_W{1'b0}};
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_overflow   <= 1'b0;
      r_cycle_cnt  <= 32'd0;
`ifdef PLC_CHECKSUM_EN
      r_checksum   <= {DATA_W{1'b0}};
`endif
    end else begin
      r_imem_we <= 1'b0;
      if (abort) begin
        r_done     <= 1'b0;
        r_timeout  <= 1'b0;
        r_overflow <= 1'b0;
        r_core_rst <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (start) begin
              r_done      <= 1'b0;
              r_timeout   <= 1'b0;
              r_overflow  <= 1'b0;
              r_cycle_cnt <= 32'd0;
              r_ptr       <= {ADDR_W{1'b0}};
`ifdef PLC_CHECKSUM_EN
              r_checksum  <= {DATA_W{1'b0}};
`endif
            end
          end
          S_LOAD: begin
            if (w_accept) begin
              r_imem_we    <= 1'b1;
              r_imem_addr  <= r_ptr;
              r_imem_wdata <= ld_data;
              r_ptr        <= r_ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
`ifdef PLC_CHECKSUM_EN
              r_checksum   <= r_checksum + ld_data;
`endif
              // Last word at the top address still releases the core.
              if (!ld_last && w_ptr_max) begin
                r_overflow <= 1'b1;
                r_done     <= 1'b1;
              end
            end
          end
          S_FLUSH: r_core_rst <= 1'b1;
          S_RUN: begin
            r_cycle_cnt <= w_cnt_next;
            if (core_halt || w_limit_hit) begin
              r_result   <= core_res;
              r_timeout  <= ~core_halt;
              r_done     <= 1'b1;
              r_core_rst <= 1'b0;
            end
          end
          default: r_core_rst <= 1'b0;
        endcase
      end
    end
  end

  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign core_rst   = r_core_rst;
  assign result     = r_result;
  assign done       = r_done;
  assign timeout    = r_timeout;
  assign overflow   = r_overflow;
  assign cycle_cnt  = r_cycle_cnt;
`ifdef PLC_CHECKSUM_EN
  assign checksum   = r_checksum;
`else
  assign checksum   = {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_program_load_controller.sv
// Bench for program_load_controller: directed scenarios plus random traffic, checked every cycle against a behavioural model.
module tb_program_load_controller;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 32;
  localparam int RES_W  = 64;
  localparam int MAXC   = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0, abort = 1'b0;
  logic              ld_valid = 1'b0, ld_last = 1'b0;
  logic [DATA_W-1:0] ld_data = 32'd0;
  logic              core_halt = 1'b0;
  logic [RES_W-1:0]  core_res = 64'd0;
  logic              ld_ready, imem_we, core_rst, done, timeout, overflow;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata, checksum;
  logic [RES_W-1:0]  result;
  logic [31:0]       cycle_cnt;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  program_load_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RES_W(RES_W), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst(rst_n), .start(start), .abort(abort),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .core_halt(core_halt), .core_res(core_res),
    .result(result), .done(done), .timeout(timeout), .overflow(overflow),
    .cycle_cnt(cycle_cnt), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: phase names describe the programme lifecycle.
  typedef enum int {P_IDLE, P_LOAD, P_WAIT, P_RUN, P_DONE} phase_t;
  phase_t      m_ph = P_IDLE;
  int          m_ptr = 0, m_addr = 0;
  bit          m_we = 0, m_crst = 0, m_done = 0, m_to = 0, m_ovf = 0;
  logic [31:0] m_wdata = 32'd0, m_sum = 32'd0;
  logic [63:0] m_res = 64'd0;
  int          m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = P_IDLE; m_ptr = 0; m_addr = 0; m_we = 0; m_crst = 0;
      m_done = 0; m_to = 0; m_ovf = 0; m_wdata = 32'd0; m_sum = 32'd0;
      m_res = 64'd0; m_cnt = 0;
    end else begin
      m_we = 0;
      if (abort) begin
        m_ph = P_IDLE; m_done = 0; m_to = 0; m_ovf = 0; m_crst = 0;
      end else if (m_ph == P_IDLE || m_ph == P_DONE) begin
        if (start) begin
          m_ph = P_LOAD; m_done = 0; m_to = 0; m_ovf = 0; m_cnt = 0;
          m_sum = 32'd0; m_ptr = 0;
        end
      end else if (m_ph == P_LOAD) begin
        if (ld_valid) begin
          m_we = 1; m_addr = m_ptr; m_wdata = ld_data; m_sum = m_sum + ld_data;
          if (ld_last) m_ph = P_WAIT;
          else if (m_ptr == DEPTH - 1) begin m_ovf = 1; m_done = 1; m_ph = P_DONE; end
          m_ptr = (m_ptr + 1) % DEPTH;
        end
      end else if (m_ph == P_WAIT) begin
        m_crst = 1; m_ph = P_RUN;
      end else begin
        m_cnt = m_cnt + 1;
        if (core_halt || m_cnt == MAXC) begin
          m_res = core_res; m_to = !core_halt; m_done = 1; m_crst = 0; m_ph = P_DONE;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ld_ready", 64'(ld_ready), 64'(m_ph == P_LOAD));
      chk("imem_we", 64'(imem_we), 64'(m_we));
      chk("imem_addr", 64'(imem_addr), 64'(m_addr));
      chk("imem_wdata", 64'(imem_wdata), 64'(m_wdata));
      chk("core_rst", 64'(core_rst), 64'(m_crst));
      chk("result", result, m_res);
      chk("done", 64'(done), 64'(m_done));
      chk("timeout", 64'(timeout), 64'(m_to));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("cycle_cnt", 64'(cycle_cnt), 64'(m_cnt));
`ifdef PLC_CHECKSUM_EN
      chk("checksum", 64'(checksum), 64'(m_sum));
`else
      chk("checksum", 64'(checksum), 64'd0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; abort = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; core_halt = 1'b0;
  endtask

  logic [31:0] prog [3];
  bit seen_crst;

  initial begin
    prog[0] = 32'h00100093; prog[1] = 32'h00200113; prog[2] = 32'h002081B3;
    #2 rst_n = 1'b0;
    cmp_en = 1'b1;
    repeat (3) tick();
    chk("rst_core_rst", 64'(core_rst), 64'd0);
    chk("rst_ld_ready", 64'(ld_ready), 64'd0);
    chk("rst_result", result, 64'd0);
    rst_n = 1'b1;
    tick();

    // Three-word program, halt on the fifth run cycle.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = prog[i]; ld_last = (i == 2);
      tick();
      chk("load_we", 64'(imem_we), 64'd1);
      chk("load_addr", 64'(imem_addr), 64'(i));
      chk("load_data", 64'(imem_wdata), 64'(prog[i]));
      chk("load_crst_low", 64'(core_rst), 64'd0);
    end
    idle_inputs();
    tick();
    chk("crst_rise", 64'(core_rst), 64'd1);
    chk("crst_we_low", 64'(imem_we), 64'd0);
    repeat (4) tick();
    core_halt = 1'b1; core_res = 64'd3; tick(); core_halt = 1'b0;
    chk("halt_result", result, 64'd3);
    chk("halt_cnt", 64'(cycle_cnt), 64'd5);
    chk("halt_done", 64'(done), 64'd1);
    chk("halt_timeout", 64'(timeout), 64'd0);
    chk("halt_crst", 64'(core_rst), 64'd0);

    // Never halt: timeout after MAXC run cycles.
    start = 1'b1; tick(); start = 1'b0;
    ld_valid = 1'b1; ld_last = 1'b1; ld_data = 32'h13; tick(); idle_inputs();
    tick();
    core_res = 64'hDEAD_BEEF_0000_0007;
    repeat (MAXC - 1) tick();
    chk("to_not_yet", 64'(done), 64'd0);
    tick();
    chk("to_done", 64'(done), 64'd1);
    chk("to_timeout", 64'(timeout), 64'd1);
    chk("to_cnt", 64'(cycle_cnt), 64'd16);
    chk("to_result", result, 64'hDEAD_BEEF_0000_0007);

    // Overflow: DEPTH words with no last marker.
    start = 1'b1; tick(); start = 1'b0;
    seen_crst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ld_valid = 1'b1; ld_data = 32'hA0 + 32'(i); tick();
      seen_crst = seen_crst | core_rst;
    end
    idle_inputs();
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_done", 64'(done), 64'd1);
    chk("ovf_addr", 64'(imem_addr), 64'd3);
    repeat (4) begin tick(); seen_crst = seen_crst | core_rst; end
    chk("ovf_crst_never", 64'(seen_crst), 64'd0);

    // Abort on the third run cycle.
    start = 1'b1; tick(); start = 1'b0;
    ld_valid = 1'b1; ld_last = 1'b1; tick(); idle_inputs();
    tick(); tick(); tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_crst", 64'(core_rst), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_ready", 64'(ld_ready), 64'd0);
    start = 1'b1; abort = 1'b1; tick(); idle_inputs();
    chk("start_abort_ready", 64'(ld_ready), 64'd0);

    // Checksum wrap.
    start = 1'b1; tick(); start = 1'b0;
    ld_valid = 1'b1; ld_data = 32'hFFFFFFFF; tick();
    ld_data = 32'h00000002; ld_last = 1'b1; tick(); idle_inputs();
`ifdef PLC_CHECKSUM_EN
    chk("checksum_wrap", 64'(checksum), 64'h1);
`else
    chk("checksum_off", 64'(checksum), 64'h0);
`endif

    // Asynchronous reset in the middle of a load.
    abort = 1'b1; tick(); abort = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    ld_valid = 1'b1; ld_data = 32'h55; tick();
    rst_n = 1'b0; #1;
    chk("arst_we", 64'(imem_we), 64'd0);
    chk("arst_ready", 64'(ld_ready), 64'd0);
    chk("arst_wdata", 64'(imem_wdata), 64'd0);
    chk("arst_result", result, 64'd0);
    idle_inputs();
    tick(); rst_n = 1'b1; tick();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      start     = ($urandom_range(0, 11) == 0);
      abort     = ($urandom_range(0, 79) == 0);
      ld_valid  = ($urandom_range(0, 2) != 0);
      ld_last   = ($urandom_range(0, 3) == 0);
      ld_data   = $urandom;
      core_halt = ($urandom_range(0, 24) == 0);
      core_res  = {$urandom, $urandom};
      tick();
    end
    idle_inputs();
    repeat (2) tick();
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
